reqrsp_mem_arbiter: RTL and testbench



---
 rtl/reqrsp_mem_arbiter_if.sv | 37 +++
 rtl/reqrsp_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_reqrsp_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reqrsp_mem_arbiter_if.sv
// Single-port SRAM macro bus shared by the reqrsp arbiter.
// master = arbiter side, slave = memory side.
interface reqrsp_mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    mem_req;
    logic                    mem_gnt;
    logic                    mem_cs;
    logic                    mem_we;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output mem_req,
        input  mem_gnt,
        output mem_cs,
        output mem_we,
        output mem_be,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        output mem_gnt,
        input  mem_cs,
        input  mem_we,
        input  mem_be,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/reqrsp_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among reqrsp ports,
// one outstanding access, response routed back to the issuing port.
module reqrsp_mem_arbiter #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_PORTS-1:0]              q_valid_i,
    output logic [NUM_PORTS-1:0]              q_ready_o,
    input  logic [NUM_PORTS-1:0]              q_write_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   q_addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   q_data_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] q_strb_i,
    output logic [NUM_PORTS-1:0]              p_valid_o,
    input  logic [NUM_PORTS-1:0]              p_ready_i,
    output logic [DATA_WIDTH-1:0]             p_data_o,
    output logic                              p_error_o,
    reqrsp_mem_arbiter_if.master              mem
);
    localparam int unsigned IDX_W  = $clog2(NUM_PORTS);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      prio_ptr_q, prio_ptr_d;
    logic                  lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic                  is_rd_q, is_rd_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  win_vld;
    logic [IDX_W-1:0]      win_idx;
    int unsigned           cand;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [STRB_W-1:0]     sel_strb;
    logic                  req;
    logic [DATA_WIDTH-1:0] resp_data;

    // A stalled (locked) request keeps the bus until granted or withdrawn.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        if (lock_vld_q && q_valid_i[lock_idx_q]) begin
            win_vld = 1'b1;
            win_idx = lock_idx_q;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cand = 32'(prio_ptr_q) + i;
                if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
                if (!win_vld && q_valid_i[cand]) begin
                    win_vld = 1'b1;
                    win_idx = IDX_W'(cand);
                end
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        sel_strb  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_write = q_write_i[i];
                sel_addr  = q_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data  = q_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = q_strb_i[i*STRB_W +: STRB_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_ptr_d = prio_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        owner_d    = owner_q;
        is_rd_d    = is_rd_q;
        rdata_d    = rdata_q;
        req        = 1'b0;
        q_ready_o  = '0;
        p_valid_o  = '0;
        resp_data  = is_rd_q ? mem.mem_rdata : '0;
        p_data_o   = rdata_q;
        unique case (state_q)
            IDLE: begin
                req = win_vld;
                if (!win_vld) begin
                    lock_vld_d = 1'b0;
                end else if (mem.mem_gnt) begin
                    q_ready_o[win_idx] = 1'b1;
                    owner_d    = win_idx;
                    is_rd_d    = ~sel_write;
                    lock_vld_d = 1'b0;
                    state_d    = RESP;
                    if (win_idx == IDX_W'(NUM_PORTS - 1)) begin
                        prio_ptr_d = '0;
                    end else begin
                        prio_ptr_d = win_idx + 1'b1;
                    end
                end else begin
                    lock_vld_d = 1'b1;
                    lock_idx_d = win_idx;
                end
            end
            RESP: begin
                p_valid_o[owner_q] = 1'b1;
                p_data_o = resp_data;
                rdata_d  = resp_data;
                state_d  = p_ready_i[owner_q] ? IDLE : HOLD;
            end
            HOLD: begin
                p_valid_o[owner_q] = 1'b1;
                if (p_ready_i[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_ni) begin
            req       = 1'b0;
            q_ready_o = '0;
            p_valid_o = '0;
        end
    end

    assign mem.mem_req   = req;
    assign mem.mem_cs    = req & mem.mem_gnt;
    assign mem.mem_we    = req & sel_write;
    assign mem.mem_be    = sel_strb;
    assign mem.mem_addr  = sel_addr;
    assign mem.mem_wdata = sel_data;
    assign p_error_o     = 1'b0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            prio_ptr_q <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            owner_q    <= '0;
            is_rd_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            prio_ptr_q <= prio_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            owner_q    <= owner_d;
            is_rd_q    <= is_rd_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule

// File: tb/tb_reqrsp_mem_arbiter.sv
// Directed bench for reqrsp_mem_arbiter with a response scoreboard
// and inline checks of the arbitration/memory side.
module tb_reqrsp_mem_arbiter;
    localparam int NP = 3;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    q_valid, q_ready, q_write;
    logic [NP-1:0]    p_valid, p_ready;
    logic [NP*AW-1:0] q_addr;
    logic [NP*DW-1:0] q_data;
    logic [NP*SW-1:0] q_strb;
    logic [DW-1:0]    p_data;
    logic             p_error;

    reqrsp_mem_arbiter_if #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) mem_if ();

    reqrsp_mem_arbiter #(
        .NUM_PORTS(NP),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .q_valid_i(q_valid),
        .q_ready_o(q_ready),
        .q_write_i(q_write),
        .q_addr_i (q_addr),
        .q_data_i (q_data),
        .q_strb_i (q_strb),
        .p_valid_o(p_valid),
        .p_ready_i(p_ready),
        .p_data_o (p_data),
        .p_error_o(p_error),
        .mem      (mem_if)
    );

    typedef struct {
        int          port;
        logic [63:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic push(input int port, input logic [63:0] data);
        rsp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic wr,
                           input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
        q_valid[k]         = 1'b1;
        q_write[k]         = wr;
        q_addr[k*AW +: AW] = a;
        q_data[k*DW +: DW] = d;
        q_strb[k*SW +: SW] = s;
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        q_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every accepted response pops one expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n) begin
            for (int k = 0; k < NP; k++) begin
                if (p_valid[k] && p_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_unexpected: port %0d data %0h",
                                 k, p_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_port", 64'(k), 64'(e.port));
                        check("rsp_data", p_data, e.data);
                        check("rsp_error", 64'(p_error), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        q_valid = '0;
        q_write = '0;
        q_addr  = '0;
        q_data  = '0;
        q_strb  = '0;
        p_ready = '1;
        mem_if.mem_gnt   = 1'b1;
        mem_if.mem_rdata = '0;

        // Outputs forced low during reset even with a pending request
        set_req(0, 1'b0, 32'h10, '0, '0);
        tick();
        tick();
        @(negedge clk);
        check("rst_q_ready", 64'(q_ready), 64'd0);
        check("rst_p_valid", 64'(p_valid), 64'd0);
        check("rst_mem_req", 64'(mem_if.mem_req), 64'd0);
        check("rst_mem_cs", 64'(mem_if.mem_cs), 64'd0);
        tick();
        rst_n   = 1'b1;
        q_valid = '0;

        // Single read by port 1
        set_req(1, 1'b0, 32'h100, '0, '0);
        @(negedge clk);
        check("rd_ready", 64'(q_ready), 64'b010);
        check("rd_addr", 64'(mem_if.mem_addr), 64'h100);
        check("rd_we", 64'(mem_if.mem_we), 64'd0);
        push(1, 64'hDEAD_BEEF_0000_0001);
        tick();
        q_valid = '0;
        mem_if.mem_rdata = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        check("rd_resp_valid", 64'(p_valid), 64'b010);
        check("rd_resp_qready", 64'(q_ready), 64'd0);
        tick();
        mem_if.mem_rdata = '0;
        @(negedge clk);
        check("rd_idle", 64'(p_valid), 64'd0);
        tick();

        // Round robin from a fresh pointer
        reset_dut();
        for (int k = 0; k < NP; k++)
            set_req(k, 1'b0, 32'h1000 + 32'(k) * 32'h10, '0, '0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("rr_ready", 64'(q_ready), 64'(1 << (j % 3)));
            check("rr_addr", 64'(mem_if.mem_addr),
                  64'h1000 + 64'((j % 3) * 16));
            push(j % 3, 64'hA000 + 64'(j));
            tick();
            mem_if.mem_rdata = 64'hA000 + 64'(j);
            @(negedge clk);
            check("rr_gap_ready", 64'(q_ready), 64'd0);
            check("rr_gap_req", 64'(mem_if.mem_req), 64'd0);
            tick();
        end
        q_valid = '0;

        // Grant stall: port 2 keeps the bus while port 0 arrives
        set_req(2, 1'b0, 32'h300, '0, '0);
        mem_if.mem_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) set_req(0, 1'b0, 32'h30, '0, '0);
            if (c == 3) mem_if.mem_gnt = 1'b1;
            @(negedge clk);
            check("lock_addr", 64'(mem_if.mem_addr), 64'h300);
            check("lock_req", 64'(mem_if.mem_req), 64'd1);
            check("lock_ready", 64'(q_ready),
                  (c == 3) ? 64'b100 : 64'd0);
            if (c == 3) push(2, 64'h3333);
            tick();
        end
        q_valid[2] = 1'b0;
        mem_if.mem_rdata = 64'h3333;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("lock_next_ready", 64'(q_ready), 64'b001);
        check("lock_next_addr", 64'(mem_if.mem_addr), 64'h30);
        push(0, 64'h3030);
        tick();
        q_valid = '0;
        mem_if.mem_rdata = 64'h3030;
        @(negedge clk);
        tick();

        // Response backpressure on port 0
        set_req(0, 1'b0, 32'h400, '0, '0);
        p_ready[0] = 1'b0;
        @(negedge clk);
        check("bp_ready", 64'(q_ready), 64'b001);
        push(0, 64'h55);
        tick();
        q_valid[0] = 1'b0;
        set_req(1, 1'b0, 32'h500, '0, '0);
        mem_if.mem_rdata = 64'h55;
        @(negedge clk);
        check("bp_resp_valid", 64'(p_valid), 64'b001);
        check("bp_resp_data", p_data, 64'h55);
        check("bp_resp_req", 64'(mem_if.mem_req), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_if.mem_rdata = 64'hFF;
            if (i == 3) p_ready[0] = 1'b1;
            @(negedge clk);
            check("bp_hold_data", p_data, 64'h55);
            check("bp_hold_valid", 64'(p_valid), 64'b001);
            check("bp_hold_req", 64'(mem_if.mem_req), 64'd0);
            tick();
        end
        @(negedge clk);
        check("bp_next_ready", 64'(q_ready), 64'b010);
        check("bp_next_addr", 64'(mem_if.mem_addr), 64'h500);
        push(1, 64'h77);
        tick();
        q_valid = '0;
        mem_if.mem_rdata = 64'h77;
        @(negedge clk);
        tick();

        // Write by port 1
        set_req(1, 1'b1, 32'h200, 64'h1234, 8'h0F);
        @(negedge clk);
        check("wr_ready", 64'(q_ready), 64'b010);
        check("wr_we", 64'(mem_if.mem_we), 64'd1);
        check("wr_be", 64'(mem_if.mem_be), 64'h0F);
        check("wr_wdata", mem_if.mem_wdata, 64'h1234);
        check("wr_cs", 64'(mem_if.mem_cs), 64'd1);
        push(1, 64'd0);
        tick();
        q_valid = '0;
        q_write = '0;
        mem_if.mem_rdata = 64'hBAD;
        @(negedge clk);
        check("wr_resp_valid", 64'(p_valid), 64'b010);
        tick();

        // Reset while port 0's response sits in HOLD
        set_req(0, 1'b0, 32'h600, '0, '0);
        p_ready[0] = 1'b0;
        @(negedge clk);
        check("mr_ready", 64'(q_ready), 64'b001);
        tick();
        q_valid = '0;
        mem_if.mem_rdata = 64'h66;
        @(negedge clk);
        check("mr_resp_valid", 64'(p_valid), 64'b001);
        tick();
        @(negedge clk);
        check("mr_hold_valid", 64'(p_valid), 64'b001);
        tick();
        rst_n = 1'b0;
        set_req(0, 1'b0, 32'h600, '0, '0);
        set_req(2, 1'b0, 32'h620, '0, '0);
        @(negedge clk);
        check("mr_rst_valid", 64'(p_valid), 64'd0);
        check("mr_rst_ready", 64'(q_ready), 64'd0);
        check("mr_rst_req", 64'(mem_if.mem_req), 64'd0);
        tick();
        rst_n   = 1'b1;
        p_ready = '1;
        @(negedge clk);
        check("mr_post_valid", 64'(p_valid), 64'd0);
        check("mr_post_ready", 64'(q_ready), 64'b001);
        check("mr_post_addr", 64'(mem_if.mem_addr), 64'h600);
        push(0, 64'h99);
        tick();
        q_valid = '0;
        mem_if.mem_rdata = 64'h99;
        @(negedge clk);
        tick();
        tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
